// File: rtl/bubble_access_sequencer_pkg.sv
// Shared types and sizing for the bubble memory access sequencer.
// Holds the state encoding, parameter defaults and datapath widths.
package bubble_access_sequencer_pkg;

  localparam int unsigned POSITION_COUNT_DEFAULT = 2053;
  localparam int unsigned WATCHDOG_LIMIT_DEFAULT = 16383;
  localparam int unsigned POS_W                  = 12;
  localparam int unsigned LEN_W                  = 10;
  localparam int unsigned WD_W                   = 14;
  localparam int unsigned COIL_W                 = 2;
  localparam int unsigned COIL_STOP_CYCLES       = 2;

  typedef enum logic [2:0] {
    IDLE,
    SEEK,
    REPLICATE,
    READOUT,
    STOPPING,
    FINISH
  } state_e;

  // States in which the bubble loop is being driven
  function automatic logic is_shifting(state_e s);
    return (s == SEEK) || (s == REPLICATE) || (s == READOUT);
  endfunction

endpackage

// File: rtl/bubble_edge_detect.sv
// Registered single-cycle edge pulse for a timing-generator input.
// DETECT_FALL selects falling-edge (1) or rising-edge (0) detection.
module bubble_edge_detect #(
  parameter bit DETECT_FALL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic pulse
);

  logic prev_q, prev_d;
  logic pulse_q, pulse_d;

  always_comb begin
    prev_d  = sig_in;
    pulse_d = DETECT_FALL ? (prev_q & ~sig_in) : (sig_in & ~prev_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/bubble_access_sequencer.sv
// Sequences one bubble-memory read: seek to position, replicate, read bits,
// then wait for the coils to stop. Tracks loop position across accesses.
module bubble_access_sequencer
  import bubble_access_sequencer_pkg::*;
#(
  parameter int unsigned POSITION_COUNT = POSITION_COUNT_DEFAULT,
  parameter int unsigned WATCHDOG_LIMIT = WATCHDOG_LIMIT_DEFAULT
) (
  input  logic             master_clock,
  input  logic             master_reset_n,
  input  logic             access_request,
  input  logic             access_abort,
  input  logic             bootloop_select,
  input  logic [POS_W-1:0] target_position,
  input  logic [LEN_W-1:0] read_length,
  input  logic             position_change,
  input  logic             data_out_strobe,
  input  logic             coil_enable,
  output logic             bubble_shift_enable,
  output logic             replicator_enable,
  output logic             bootloop_enable,
  output logic             bit_sample,
  output logic [POS_W-1:0] current_position,
  output logic             busy,
  output logic             done,
  output logic             error
);

  state_e              state_q, state_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [POS_W-1:0]    target_q, target_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [COIL_W-1:0]   coil_cnt_q, coil_cnt_d;
  logic                boot_q, boot_d;
  logic                shift_en_q, shift_en_d;
  logic                repl_en_q, repl_en_d;
  logic                boot_en_q, boot_en_d;
  logic                bit_sample_q, bit_sample_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                pos_rise;
  logic                strobe_fall;

  bubble_edge_detect #(.DETECT_FALL(1'b0)) u_pos_edge (
    .clk    (master_clock),
    .rst_n  (master_reset_n),
    .sig_in (position_change),
    .pulse  (pos_rise)
  );

  bubble_edge_detect #(.DETECT_FALL(1'b1)) u_strobe_edge (
    .clk    (master_clock),
    .rst_n  (master_reset_n),
    .sig_in (data_out_strobe),
    .pulse  (strobe_fall)
  );

  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    target_d     = target_q;
    len_d        = len_q;
    boot_d       = boot_q;
    bit_cnt_d    = bit_cnt_q;
    wd_d         = '0;
    coil_cnt_d   = '0;
    bit_sample_d = 1'b0;
    error_d      = error_q;

    if (pos_rise) begin
      pos_d = (pos_q == POS_W'(POSITION_COUNT - 1)) ? '0 : pos_q + POS_W'(1);
    end
    // Watchdog restarts on every loop step and idles outside shifting states
    if (is_shifting(state_q) && !pos_rise) begin
      wd_d = wd_q + WD_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (access_request) begin
          target_d  = POS_W'(32'(target_position) % POSITION_COUNT);
          len_d     = (read_length == '0) ? LEN_W'(1) : read_length;
          boot_d    = bootloop_select;
          error_d   = 1'b0;
          bit_cnt_d = '0;
          state_d   = SEEK;
        end
      end
      SEEK: begin
        if (pos_rise && (pos_d == target_q)) state_d = REPLICATE;
      end
      REPLICATE: begin
        if (pos_rise) state_d = READOUT;
      end
      READOUT: begin
        if (strobe_fall) begin
          bit_sample_d = 1'b1;
          bit_cnt_d    = bit_cnt_q + LEN_W'(1);
          if (bit_cnt_d == len_q) state_d = STOPPING;
        end
      end
      STOPPING: begin
        if (coil_enable) begin
          coil_cnt_d = (coil_cnt_q == COIL_W'(COIL_STOP_CYCLES)) ? coil_cnt_q
                                                                 : coil_cnt_q + COIL_W'(1);
        end
        if (coil_cnt_d == COIL_W'(COIL_STOP_CYCLES)) state_d = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort outranks watchdog and normal completion
    if (is_shifting(state_q)) begin
      if (access_abort) begin
        state_d      = STOPPING;
        bit_sample_d = 1'b0;
      end else if (wd_d == WD_W'(WATCHDOG_LIMIT)) begin
        error_d = 1'b1;
        state_d = STOPPING;
      end
    end

    shift_en_d = !is_shifting(state_d);
    repl_en_d  = (state_d != REPLICATE);
    boot_en_d  = boot_d && (state_d != IDLE) && (state_d != FINISH);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == FINISH);
  end

  always_ff @(posedge master_clock) begin
    if (!master_reset_n) begin
      state_q      <= IDLE;
      pos_q        <= '0;
      target_q     <= '0;
      len_q        <= '0;
      boot_q       <= 1'b0;
      bit_cnt_q    <= '0;
      wd_q         <= '0;
      coil_cnt_q   <= '0;
      shift_en_q   <= 1'b1;
      repl_en_q    <= 1'b1;
      boot_en_q    <= 1'b0;
      bit_sample_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      target_q     <= target_d;
      len_q        <= len_d;
      boot_q       <= boot_d;
      bit_cnt_q    <= bit_cnt_d;
      wd_q         <= wd_d;
      coil_cnt_q   <= coil_cnt_d;
      shift_en_q   <= shift_en_d;
      repl_en_q    <= repl_en_d;
      boot_en_q    <= boot_en_d;
      bit_sample_q <= bit_sample_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign bubble_shift_enable = shift_en_q;
  assign replicator_enable   = repl_en_q;
  assign bootloop_enable     = boot_en_q;
  assign bit_sample          = bit_sample_q;
  assign current_position    = pos_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign error               = error_q;

endmodule

// File: tb/tb_bubble_access_sequencer.sv
// Bench for bubble_access_sequencer: directed scenarios plus randomized
// accesses checked against a position/bit-count model.
module tb_bubble_access_sequencer;

  localparam int unsigned PC = 2053;
  localparam int unsigned WL = 16383;

  logic        master_clock = 1'b0;
  logic        master_reset_n;
  logic        access_request;
  logic        access_abort;
  logic        bootloop_select;
  logic [11:0] target_position;
  logic [9:0]  read_length;
  logic        position_change;
  logic        data_out_strobe;
  logic        coil_enable;
  logic        bubble_shift_enable;
  logic        replicator_enable;
  logic        bootloop_enable;
  logic        bit_sample;
  logic [11:0] current_position;
  logic        busy;
  logic        done;
  logic        error;

  int n_checks   = 0;
  int n_pass     = 0;
  int bits_seen  = 0;
  int dones_seen = 0;
  int exp_pos    = 0;

  bubble_access_sequencer #(.POSITION_COUNT(PC), .WATCHDOG_LIMIT(WL)) dut (
    .master_clock        (master_clock),
    .master_reset_n      (master_reset_n),
    .access_request      (access_request),
    .access_abort        (access_abort),
    .bootloop_select     (bootloop_select),
    .target_position     (target_position),
    .read_length         (read_length),
    .position_change     (position_change),
    .data_out_strobe     (data_out_strobe),
    .coil_enable         (coil_enable),
    .bubble_shift_enable (bubble_shift_enable),
    .replicator_enable   (replicator_enable),
    .bootloop_enable     (bootloop_enable),
    .bit_sample          (bit_sample),
    .current_position    (current_position),
    .busy                (busy),
    .done                (done),
    .error               (error)
  );

  always #5 master_clock = ~master_clock;

  always @(posedge master_clock) begin
    if (bit_sample === 1'b1) bits_seen++;
    if (done === 1'b1) dones_seen++;
  end

  task automatic cycle(input int n);
    repeat (n) @(negedge master_clock);
  endtask

  // One +Y step; the model position advances with it
  task automatic pulse_pos(input int hi);
    position_change = 1'b1;
    repeat (hi) @(negedge master_clock);
    position_change = 1'b0;
    repeat (2) @(negedge master_clock);
    exp_pos = (exp_pos + 1) % PC;
  endtask

  task automatic pulse_strobe();
    data_out_strobe = 1'b1;
    @(negedge master_clock);
    data_out_strobe = 1'b0;
    repeat (2) @(negedge master_clock);
  endtask

  task automatic request(input logic [11:0] tgt, input logic [9:0] len, input logic boot);
    access_request  = 1'b1;
    target_position = tgt;
    read_length     = len;
    bootloop_select = boot;
    @(negedge master_clock);
    access_request  = 1'b0;
  endtask

  task automatic abort_pulse();
    access_abort = 1'b1;
    @(negedge master_clock);
    access_abort = 1'b0;
  endtask

  task automatic test_reset();
    master_reset_n = 1'b0;
    cycle(3);
    n_checks++; if (bubble_shift_enable !== 1'b1) $display("FAIL reset_shift: got %b expected 1", bubble_shift_enable); else n_pass++;
    n_checks++; if (replicator_enable !== 1'b1) $display("FAIL reset_repl: got %b expected 1", replicator_enable); else n_pass++;
    n_checks++; if (bootloop_enable !== 1'b0) $display("FAIL reset_boot: got %b expected 0", bootloop_enable); else n_pass++;
    n_checks++; if (bit_sample !== 1'b0) $display("FAIL reset_bit_sample: got %b expected 0", bit_sample); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
    n_checks++; if (error !== 1'b0) $display("FAIL reset_error: got %b expected 0", error); else n_pass++;
    n_checks++; if (current_position !== 12'd0) $display("FAIL reset_pos: got %0d expected 0", current_position); else n_pass++;
    master_reset_n = 1'b1;
    exp_pos = 0;
    cycle(2);
  endtask

  task automatic test_basic();
    int b0, d0;
    b0 = bits_seen; d0 = dones_seen;
    coil_enable = 1'b0;
    request(12'd5, 10'd4, 1'b1);
    n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b expected 1", busy); else n_pass++;
    n_checks++; if (bubble_shift_enable !== 1'b0) $display("FAIL basic_shift_on: got %b expected 0", bubble_shift_enable); else n_pass++;
    n_checks++; if (bootloop_enable !== 1'b1) $display("FAIL basic_boot: got %b expected 1", bootloop_enable); else n_pass++;
    repeat (4) pulse_pos(2);
    n_checks++; if (current_position !== 12'(exp_pos)) $display("FAIL basic_pos4: got %0d expected %0d", current_position, exp_pos); else n_pass++;
    n_checks++; if (replicator_enable !== 1'b1) $display("FAIL basic_repl_early: got %b expected 1", replicator_enable); else n_pass++;
    pulse_pos(2);
    n_checks++; if (current_position !== 12'd5) $display("FAIL basic_pos5: got %0d expected 5", current_position); else n_pass++;
    n_checks++; if (replicator_enable !== 1'b0) $display("FAIL basic_repl_on: got %b expected 0", replicator_enable); else n_pass++;
    pulse_pos(2);
    n_checks++; if (replicator_enable !== 1'b1) $display("FAIL basic_repl_off: got %b expected 1", replicator_enable); else n_pass++;
    n_checks++; if (bubble_shift_enable !== 1'b0) $display("FAIL basic_readout_shift: got %b expected 0", bubble_shift_enable); else n_pass++;
    repeat (4) pulse_strobe();
    cycle(1);
    n_checks++; if (bits_seen - b0 !== 4) $display("FAIL basic_bits: got %0d expected 4", bits_seen - b0); else n_pass++;
    n_checks++; if (bubble_shift_enable !== 1'b1) $display("FAIL basic_stopping_shift: got %b expected 1", bubble_shift_enable); else n_pass++;
    cycle(3);
    n_checks++; if (dones_seen - d0 !== 0) $display("FAIL basic_early_done: got %0d expected 0", dones_seen - d0); else n_pass++;
    coil_enable = 1'b1;
    cycle(2);
    n_checks++; if (done !== 1'b1) $display("FAIL basic_done: got %b expected 1", done); else n_pass++;
    n_checks++; if (bootloop_enable !== 1'b0) $display("FAIL basic_boot_finish: got %b expected 0", bootloop_enable); else n_pass++;
    cycle(2);
    n_checks++; if (busy !== 1'b0) $display("FAIL basic_idle: got %b expected 0", busy); else n_pass++;
    n_checks++; if (dones_seen - d0 !== 1) $display("FAIL basic_done_count: got %0d expected 1", dones_seen - d0); else n_pass++;
  endtask

  task automatic test_wrap();
    int d0, n;
    d0 = dones_seen;
    coil_enable = 1'b1;
    n = (2050 - exp_pos + PC) % PC;
    repeat (n) pulse_pos(1);
    n_checks++; if (current_position !== 12'd2050) $display("FAIL wrap_start: got %0d expected 2050", current_position); else n_pass++;
    request(12'd1, 10'd1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      pulse_pos(1);
      n_checks++; if (current_position !== 12'(exp_pos)) $display("FAIL wrap_pos: got %0d expected %0d", current_position, exp_pos); else n_pass++;
      n_checks++; if (replicator_enable !== (i == 3 ? 1'b0 : 1'b1)) $display("FAIL wrap_repl: got %b step %0d", replicator_enable, i); else n_pass++;
    end
    pulse_pos(1);
    pulse_strobe();
    cycle(4);
    n_checks++; if (dones_seen - d0 !== 1) $display("FAIL wrap_done: got %0d expected 1", dones_seen - d0); else n_pass++;
  endtask

  task automatic test_abort();
    int b0, d0;
    b0 = bits_seen; d0 = dones_seen;
    coil_enable = 1'b0;
    request(12'((exp_pos + 2) % PC), 10'd8, 1'b0);
    repeat (2) pulse_pos(2);
    n_checks++; if (replicator_enable !== 1'b0) $display("FAIL abort_repl: got %b expected 0", replicator_enable); else n_pass++;
    pulse_pos(2);
    repeat (2) pulse_strobe();
    cycle(1);
    n_checks++; if (bits_seen - b0 !== 2) $display("FAIL abort_bits_before: got %0d expected 2", bits_seen - b0); else n_pass++;
    n_checks++; if (bubble_shift_enable !== 1'b0) $display("FAIL abort_shift_before: got %b expected 0", bubble_shift_enable); else n_pass++;
    abort_pulse();
    n_checks++; if (bubble_shift_enable !== 1'b1) $display("FAIL abort_shift_after: got %b expected 1", bubble_shift_enable); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL abort_busy: got %b expected 1", busy); else n_pass++;
    repeat (2) pulse_strobe();
    cycle(2);
    n_checks++; if (bits_seen - b0 !== 2) $display("FAIL abort_bits_after: got %0d expected 2", bits_seen - b0); else n_pass++;
    n_checks++; if (dones_seen - d0 !== 0) $display("FAIL abort_early_done: got %0d expected 0", dones_seen - d0); else n_pass++;
    coil_enable = 1'b1;
    cycle(4);
    n_checks++; if (dones_seen - d0 !== 1) $display("FAIL abort_done: got %0d expected 1", dones_seen - d0); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_idle: got %b expected 0", busy); else n_pass++;
  endtask

  task automatic test_watchdog();
    int d0, k;
    d0 = dones_seen;
    coil_enable = 1'b1;
    request(12'((exp_pos + 5) % PC), 10'd4, 1'b1);
    k = 0;
    while (error !== 1'b1 && k < int'(WL) + 100) begin
      @(negedge master_clock);
      k++;
    end
    n_checks++; if (error !== 1'b1) $display("FAIL wd_error: got %b expected 1 after %0d cycles", error, k); else n_pass++;
    n_checks++; if (k < int'(WL) - 1 || k > int'(WL) + 2) $display("FAIL wd_latency: got %0d expected about %0d", k, WL); else n_pass++;
    n_checks++; if (bubble_shift_enable !== 1'b1) $display("FAIL wd_stopping: got %b expected 1", bubble_shift_enable); else n_pass++;
    cycle(4);
    n_checks++; if (dones_seen - d0 !== 1) $display("FAIL wd_done: got %0d expected 1", dones_seen - d0); else n_pass++;
    n_checks++; if (error !== 1'b1) $display("FAIL wd_sticky: got %b expected 1", error); else n_pass++;
    request(12'((exp_pos + 5) % PC), 10'd4, 1'b0);
    n_checks++; if (error !== 1'b0) $display("FAIL wd_clear: got %b expected 0", error); else n_pass++;
    abort_pulse();
    cycle(4);
    n_checks++; if (busy !== 1'b0) $display("FAIL wd_idle: got %b expected 0", busy); else n_pass++;
  endtask

  task automatic test_busy_ignore();
    coil_enable = 1'b1;
    request(12'((exp_pos + 3) % PC), 10'd3, 1'b0);
    cycle(1);
    request(12'((exp_pos + 1) % PC), 10'd7, 1'b1);
    n_checks++; if (bootloop_enable !== 1'b0) $display("FAIL busy_boot: got %b expected 0", bootloop_enable); else n_pass++;
    pulse_pos(1);
    n_checks++; if (replicator_enable !== 1'b1) $display("FAIL busy_target_kept: got %b expected 1", replicator_enable); else n_pass++;
    repeat (2) pulse_pos(1);
    n_checks++; if (replicator_enable !== 1'b0) $display("FAIL busy_repl: got %b expected 0", replicator_enable); else n_pass++;
    pulse_pos(1);
    repeat (3) pulse_strobe();
    cycle(1);
    n_checks++; if (bubble_shift_enable !== 1'b1) $display("FAIL busy_len_kept: got %b expected 1", bubble_shift_enable); else n_pass++;
    cycle(4);
    n_checks++; if (busy !== 1'b0) $display("FAIL busy_idle: got %b expected 0", busy); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int d0;
    d0 = dones_seen;
    coil_enable = 1'b1;
    request(12'((exp_pos + 1) % PC), 10'd4, 1'b1);
    pulse_pos(2);
    n_checks++; if (replicator_enable !== 1'b0) $display("FAIL rmid_repl: got %b expected 0", replicator_enable); else n_pass++;
    master_reset_n = 1'b0;
    @(negedge master_clock);
    n_checks++; if (bubble_shift_enable !== 1'b1) $display("FAIL rmid_shift: got %b expected 1", bubble_shift_enable); else n_pass++;
    n_checks++; if (replicator_enable !== 1'b1) $display("FAIL rmid_repl_off: got %b expected 1", replicator_enable); else n_pass++;
    n_checks++; if (bootloop_enable !== 1'b0) $display("FAIL rmid_boot: got %b expected 0", bootloop_enable); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (current_position !== 12'd0) $display("FAIL rmid_pos: got %0d expected 0", current_position); else n_pass++;
    master_reset_n = 1'b1;
    exp_pos = 0;
    cycle(4);
    n_checks++; if (dones_seen - d0 !== 0) $display("FAIL rmid_no_done: got %0d expected 0", dones_seen - d0); else n_pass++;
  endtask

  task automatic test_random();
    int d, raw, tgt, len, exp_len, b0, d0;
    logic boot;
    coil_enable = 1'b1;
    for (int it = 0; it < 8; it++) begin
      b0 = bits_seen; d0 = dones_seen;
      d = int'($urandom_range(1, 12));
      tgt = (exp_pos + d) % PC;
      raw = tgt;
      if ($urandom_range(0, 1) == 1 && raw + int'(PC) <= 4095) raw = raw + int'(PC);
      len = int'($urandom_range(0, 12));
      exp_len = (len == 0) ? 1 : len;
      boot = 1'($urandom_range(0, 1));
      request(12'(raw), 10'(len), boot);
      repeat (d - 1) pulse_pos(int'($urandom_range(1, 3)));
      n_checks++; if (replicator_enable !== 1'b1) $display("FAIL rnd_seek: got %b expected 1 it %0d", replicator_enable, it); else n_pass++;
      pulse_pos(int'($urandom_range(1, 3)));
      n_checks++; if (current_position !== 12'(tgt)) $display("FAIL rnd_pos: got %0d expected %0d", current_position, tgt); else n_pass++;
      n_checks++; if (replicator_enable !== 1'b0) $display("FAIL rnd_repl: got %b expected 0 it %0d", replicator_enable, it); else n_pass++;
      pulse_pos(int'($urandom_range(1, 3)));
      repeat (exp_len - 1) pulse_strobe();
      cycle(1);
      n_checks++; if (bubble_shift_enable !== 1'b0) $display("FAIL rnd_readout: got %b expected 0 it %0d", bubble_shift_enable, it); else n_pass++;
      pulse_strobe();
      cycle(1);
      n_checks++; if (bubble_shift_enable !== 1'b1) $display("FAIL rnd_stop: got %b expected 1 it %0d", bubble_shift_enable, it); else n_pass++;
      n_checks++; if (bits_seen - b0 !== exp_len) $display("FAIL rnd_bits: got %0d expected %0d", bits_seen - b0, exp_len); else n_pass++;
      n_checks++; if (bootloop_enable !== boot) $display("FAIL rnd_boot: got %b expected %b", bootloop_enable, boot); else n_pass++;
      cycle(4);
      n_checks++; if (dones_seen - d0 !== 1) $display("FAIL rnd_done: got %0d expected 1", dones_seen - d0); else n_pass++;
    end
  endtask

  initial begin
    master_reset_n  = 1'b0;
    access_request  = 1'b0;
    access_abort    = 1'b0;
    bootloop_select = 1'b0;
    target_position = '0;
    read_length     = '0;
    position_change = 1'b0;
    data_out_strobe = 1'b0;
    coil_enable     = 1'b1;
    test_reset();
    test_basic();
    test_wrap();
    test_abort();
    test_watchdog();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
